// File: rtl/platform_pio_arbiter.sv
// Two-requester round-robin arbiter in front of an Avalon PIO slave.
// Each grant runs one PIO access: IDLE -> ACCESS -> (CAPTURE | SETTLE) -> DONE.
module platform_pio_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [1:0]  addr0,
    input  logic [1:0]  addr1,
    input  logic [1:0]  wdata0,
    input  logic [1:0]  wdata1,
    output logic        done0,
    output logic        done1,
    output logic [1:0]  rdata,
    output logic        busy,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  addr_q, addr_d;
    logic [1:0]  wdata_q, wdata_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  rdata_q, rdata_d;
    logic        pick1;
    logic        unused_readdata;

    assign unused_readdata = ^pio_readdata[31:2];

    // On a tie the requester not served last wins; a lone request always wins.
    assign pick1 = req1 & (~req0 | ~last_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_d           = wr_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        gnt_d          = gnt_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        done0          = 1'b0;
        done1          = 1'b0;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    gnt_d   = pick1;
                    wr_d    = pick1 ? wr1    : wr0;
                    addr_d  = pick1 ? addr1  : addr0;
                    wdata_d = pick1 ? wdata1 : wdata0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                pio_chipselect = 1'b1;
                pio_write_n    = ~wr_q;
                if (!wr_q) begin
                    state_d = S_CAPTURE;
                end else if (SETTLE_CYCLES != 0) begin
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_CAPTURE: begin
                // Slave readdata is registered, so it now reflects the ACCESS address.
                rdata_d = pio_readdata[1:0];
                state_d = S_DONE;
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                done0   = ~gnt_q;
                done1   = gnt_q;
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign pio_address   = addr_q;
    assign pio_writedata = {30'b0, wdata_q};
    assign rdata         = rdata_q;

endmodule

// File: tb/tb_platform_pio_arbiter.sv
// Directed bench for platform_pio_arbiter: one SETTLE_CYCLES=0 instance with a
// registered PIO model, plus SETTLE_CYCLES=4 and =1 instances for settle/abort.
module tb_platform_pio_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, wr0, wr1;
    logic [1:0]  addr0, addr1, wdata0, wdata1;

    logic        m_done0, m_done1, m_busy, m_cs, m_wn;
    logic [1:0]  m_rdata, m_addr;
    logic [31:0] m_wd, m_rd;

    logic        s4_req0, s4_req1, s4_done0, s4_done1, s4_busy, s4_cs, s4_wn;
    logic [1:0]  s4_rdata, s4_addr;
    logic [31:0] s4_wd;

    logic        s1_req0, s1_req1, s1_done0, s1_done1, s1_busy, s1_cs, s1_wn;
    logic [1:0]  s1_rdata, s1_addr;
    logic [31:0] s1_wd;

    logic [31:0] zero32;

    int total;
    int bad;

    platform_pio_arbiter #(.SETTLE_CYCLES(0)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(m_done0), .done1(m_done1), .rdata(m_rdata), .busy(m_busy),
        .pio_address(m_addr), .pio_chipselect(m_cs), .pio_write_n(m_wn),
        .pio_writedata(m_wd), .pio_readdata(m_rd)
    );

    platform_pio_arbiter #(.SETTLE_CYCLES(4)) u_dut_s4 (
        .clk(clk), .reset(reset),
        .req0(s4_req0), .req1(s4_req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(s4_done0), .done1(s4_done1), .rdata(s4_rdata), .busy(s4_busy),
        .pio_address(s4_addr), .pio_chipselect(s4_cs), .pio_write_n(s4_wn),
        .pio_writedata(s4_wd), .pio_readdata(zero32)
    );

    platform_pio_arbiter #(.SETTLE_CYCLES(1)) u_dut_s1 (
        .clk(clk), .reset(reset),
        .req0(s1_req0), .req1(s1_req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(s1_done0), .done1(s1_done1), .rdata(s1_rdata), .busy(s1_busy),
        .pio_address(s1_addr), .pio_chipselect(s1_cs), .pio_write_n(s1_wn),
        .pio_writedata(s1_wd), .pio_readdata(zero32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave: data reg reads 2'b10, direction reg reads 2'b01, others 0; one cycle late.
    always_ff @(posedge clk) begin
        case (m_addr)
            2'd0:    m_rd <= 32'h2;
            2'd1:    m_rd <= 32'h1;
            default: m_rd <= 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        zero32 = '0;
        reset = 1'b1;
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        s4_req0 = 0; s4_req1 = 0; s1_req0 = 0; s1_req1 = 0;

        tick();
        chk("rst_busy", m_busy, 0);
        chk("rst_done0", m_done0, 0);
        chk("rst_done1", m_done1, 0);
        chk("rst_cs", m_cs, 0);
        chk("rst_wn", m_wn, 1);
        chk("rst_addr", m_addr, 0);
        chk("rst_wd", m_wd, 0);
        chk("rst_rdata", m_rdata, 0);

        // Write from requester 0, no settle
        reset = 1'b0;
        req0 = 1; wr0 = 1; addr0 = 2'd1; wdata0 = 2'b11;
        tick();
        chk("wr_cs", m_cs, 1);
        chk("wr_wn", m_wn, 0);
        chk("wr_addr", m_addr, 1);
        chk("wr_wd", m_wd, 3);
        chk("wr_busy", m_busy, 1);
        chk("wr_nodone", m_done0, 0);
        tick();
        chk("wr_done0", m_done0, 1);
        chk("wr_done1", m_done1, 0);
        chk("wr_done_cs", m_cs, 0);
        chk("wr_done_wn", m_wn, 1);
        chk("wr_done_addr", m_addr, 1);
        req0 = 0;
        tick();
        chk("wr_idle_busy", m_busy, 0);
        chk("wr_idle_done0", m_done0, 0);

        // Read of data register by requester 1
        req1 = 1; wr1 = 0; addr1 = 2'd0;
        tick();
        chk("rd_cs", m_cs, 1);
        chk("rd_wn", m_wn, 1);
        chk("rd_addr", m_addr, 0);
        chk("rd_acc_done1", m_done1, 0);
        tick();
        chk("rd_cap_cs", m_cs, 0);
        chk("rd_cap_done1", m_done1, 0);
        chk("rd_cap_busy", m_busy, 1);
        tick();
        chk("rd_done1", m_done1, 1);
        chk("rd_done0", m_done0, 0);
        chk("rd_rdata", m_rdata, 2'b10);
        req1 = 0;
        tick();
        chk("rd_hold_rdata", m_rdata, 2'b10);
        chk("rd_idle_busy", m_busy, 0);

        // Read of direction register by requester 0
        req0 = 1; wr0 = 0; addr0 = 2'd1;
        tick();
        tick();
        tick();
        chk("rdir_done0", m_done0, 1);
        chk("rdir_rdata", m_rdata, 2'b01);
        req0 = 0;
        tick();

        // Read of unmapped address 2, requester 0 again
        req0 = 1; wr0 = 0; addr0 = 2'd2;
        tick();
        chk("r2_addr", m_addr, 2);
        tick();
        tick();
        chk("r2_done0", m_done0, 1);
        chk("r2_rdata", m_rdata, 0);
        req0 = 0;
        tick();

        // Inputs change and req drops after grant
        req0 = 1; wr0 = 1; addr0 = 2'd1; wdata0 = 2'd1;
        tick();
        addr0 = 2'd2; wdata0 = 2'd2; req0 = 0; wr0 = 0;
        chk("stab_cs", m_cs, 1);
        chk("stab_wn", m_wn, 0);
        chk("stab_addr", m_addr, 1);
        chk("stab_wd", m_wd, 1);
        tick();
        chk("stab_done0", m_done0, 1);
        chk("stab_addr_hold", m_addr, 1);
        tick();
        chk("stab_idle", m_busy, 0);

        // Tie from reset release: grants 0,1,0,1 with one IDLE cycle between
        reset = 1'b1;
        req0 = 1; req1 = 1; wr0 = 1; wr1 = 1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("tie_busy_%0d", k), m_busy, (k % 3) != 0);
            chk($sformatf("tie_done0_%0d", k), m_done0, (k == 2) || (k == 8));
            chk($sformatf("tie_done1_%0d", k), m_done1, (k == 5) || (k == 11));
        end
        req0 = 0; req1 = 0;
        tick();

        // Settle: 4 cycles gives done at +6, 1 cycle gives done at +3
        s4_req0 = 1; s1_req0 = 1; wr0 = 1; addr0 = 2'd1; wdata0 = 2'd2;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("s4_busy_%0d", k), s4_busy, k <= 6);
            chk($sformatf("s4_done0_%0d", k), s4_done0, k == 6);
            chk($sformatf("s4_cs_%0d", k), s4_cs, k == 1);
            chk($sformatf("s1_busy_%0d", k), s1_busy, k <= 3);
            chk($sformatf("s1_done0_%0d", k), s1_done0, k == 3);
            if (k == 3) s1_req0 = 0;
            if (k == 6) s4_req0 = 0;
        end

        // Abort during SETTLE; pending requester 1 then served normally
        s4_req0 = 1; wr0 = 1; addr0 = 2'd3; wdata0 = 2'd1;
        wr1 = 1; addr1 = 2'd2; wdata1 = 2'd3;
        tick();
        chk("ab_acc_addr", s4_addr, 3);
        chk("ab_acc_wd", s4_wd, 1);
        s4_req1 = 1;
        tick();
        tick();
        chk("ab_settle_busy", s4_busy, 1);
        reset = 1'b1;
        s4_req0 = 0;
        #1;
        chk("ab_busy", s4_busy, 0);
        chk("ab_done0", s4_done0, 0);
        chk("ab_done1", s4_done1, 0);
        chk("ab_cs", s4_cs, 0);
        chk("ab_wn", s4_wn, 1);
        chk("ab_addr", s4_addr, 0);
        chk("ab_wd", s4_wd, 0);
        tick();
        chk("ab_hold_busy", s4_busy, 0);
        chk("ab_hold_done0", s4_done0, 0);
        reset = 1'b0;
        tick();
        chk("ab_g1_cs", s4_cs, 1);
        chk("ab_g1_addr", s4_addr, 2);
        chk("ab_g1_wd", s4_wd, 3);
        chk("ab_g1_wn", s4_wn, 0);
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk($sformatf("ab_done1_%0d", k), s4_done1, k == 6);
            chk($sformatf("ab_done0_%0d", k), s4_done0, 0);
        end
        s4_req1 = 0;
        tick();
        chk("ab_end_busy", s4_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/platform_pio_arbiter.md
PLATFORM_PIO_ARBITER -- requirements
Module: platform_pio_arbiter

Interface
REQ-001 Parameter: SETTLE_CYCLES, 0, extra idle cycles inserted after every PIO write before done (0..255).
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0 / req1  input  1  per-requester transaction request; level, held until matching done.
REQ-005 wr0 / wr1  input  1  1 = write, 0 = read; sampled at grant.
REQ-006 addr0 / addr1  input  2  PIO register address (0 = data, 1 = direction); sampled at grant.
REQ-007 wdata0 / wdata1  input  2  write payload; sampled at grant.
REQ-008 done0 / done1  output  1  one-cycle completion pulse to the granted requester.
REQ-009 rdata  output  2  read result; valid in the done cycle, held until the next capture.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 pio_address  output  2  Avalon address to the PIO slave.
REQ-012 pio_chipselect  output  1  Avalon chipselect.
REQ-013 pio_write_n  output  1  Avalon active-low write strobe.
REQ-014 pio_writedata  output  32  {30'b0, latched wdata}.
REQ-015 pio_readdata  input  32  PIO readdata; registered in the slave, so it reflects pio_address one cycle late.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, CAPTURE, SETTLE, DONE.
REQ-017 IDLE: if any req is high, the arbiter SHALL grant one, latch its wr/addr/wdata and the grant index, and go to ACCESS; otherwise stay.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; with one high, it wins regardless of history.
REQ-019 ACCESS (exactly 1 cycle): pio_chipselect=1, pio_address=latched addr, pio_write_n=~latched wr; next state CAPTURE for reads, SETTLE for writes when SETTLE_CYCLES>0, else DONE.
REQ-020 In all states except ACCESS: pio_chipselect=0, pio_write_n=1; pio_address SHALL hold the latched address (required for CAPTURE).
REQ-021 CAPTURE (exactly 1 cycle): rdata SHALL load pio_readdata[1:0] at the end of the cycle; next state DONE.
REQ-022 SETTLE: an 8-bit counter SHALL load SETTLE_CYCLES-1 on entry and decrement each cycle; exit to DONE in the cycle the counter is 0, giving exactly SETTLE_CYCLES cycles in SETTLE.
REQ-023 DONE (exactly 1 cycle): done of the granted requester SHALL be 1, the other 0; the last-grant record SHALL update; next state IDLE.
REQ-024 Latency from req sampled in IDLE to done: write 2 cycles + SETTLE_CYCLES; read 3 cycles.
REQ-025 A requester deasserting req mid-transaction SHALL NOT abort it; done still pulses.
REQ-026 A req held high through its done cycle SHALL be treated as a new request in the following IDLE cycle; minimum spacing between grants is 1 IDLE cycle.
REQ-027 Changes to wr/addr/wdata after grant SHALL NOT affect the transaction in flight.
REQ-028 Reads of address 2 or 3 SHALL complete normally and return the slave value (0).

Reset
REQ-029 While reset is high: state IDLE, counter 0, done0=done1=0, rdata=0, busy=0, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, last-grant = requester 1 (so requester 0 wins the first tie).
REQ-030 Reset asserted mid-transaction SHALL abort it asynchronously with no done pulse and no further PIO access.

Verification
REQ-031 Write: req0 wr0=1 addr0=1 wdata0=2'b11, SETTLE_CYCLES=0 -> one ACCESS cycle with chipselect=1, write_n=0, address=1, writedata=3; done0 two cycles after sampled req.
REQ-032 Read: PIO model readdata lags address by 1 cycle and returns 2'b10 at address 0; req1 wr1=0 addr1=0 -> write_n=1 in ACCESS, rdata=2'b10 with done1 3 cycles after req.
REQ-033 Tie: req0=req1=1 continuously from reset release -> grants alternate 0,1,0,1; each done separated by exactly one IDLE cycle.
REQ-034 Settle: SETTLE_CYCLES=4, write from req0 -> busy high 6 cycles, done0 6 cycles after req; SETTLE_CYCLES=1 -> 3 cycles.
REQ-035 Abort: assert reset during SETTLE -> outputs at reset values immediately, no done; after release, pending req1 granted normally.
REQ-036 Stability: change addr0/wdata0 the cycle after grant and drop req0 -> PIO access uses original values, done0 still pulses.
